// File: rtl/instr_cache.sv
// Direct-mapped, one-word-per-line instruction cache with a single
// outstanding refill to backing memory and a saturating miss counter.
module instr_cache #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        srst,
    input  logic [31:0] pc_f,
    input  logic        inval,
    output logic [31:0] instr_f,
    output logic        stall_o,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [15:0] miss_cnt
);
    localparam int IB = $clog2(LINES);
    localparam int TW = 30 - IB;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t            state;
    logic [LINES-1:0]  valid;
    logic [TW-1:0]     tag_arr  [LINES];
    logic [31:0]       data_arr [LINES];
    logic              inval_pend;
    logic [29:0]       miss_addr;

    logic [IB-1:0]     idx;
    logic [TW-1:0]     tag;
    logic [IB-1:0]     fill_idx;
    logic [TW-1:0]     fill_tag;
    logic              hit;
    logic              fill_we;
    logic              unused_pc_lsb;

    assign idx           = pc_f[IB+1:2];
    assign tag           = pc_f[31:IB+2];
    assign fill_idx      = miss_addr[IB-1:0];
    assign fill_tag      = miss_addr[29:IB];
    assign unused_pc_lsb = ^pc_f[1:0];

    // Lookup is gated by reset so the fetch stage sees a stall/NOP even
    // before the first reset edge has cleared the valid bits.
    assign hit      = srst && (state == IDLE) && valid[idx] && (tag_arr[idx] == tag);
    assign instr_f  = hit ? data_arr[idx] : NOP;
    assign stall_o  = !hit;
    assign mem_addr = {miss_addr, 2'b00};
    assign fill_we  = srst && (state == REFILL) && mem_ack;

    // Tag/data storage: no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= mem_rdata;
        end
    end

    // Control FSM: miss detection, refill handshake, invalidation, counter.
    always_ff @(posedge clk) begin
        if (!srst) begin
            state      <= IDLE;
            valid      <= '0;
            inval_pend <= 1'b0;
            miss_cnt   <= '0;
            mem_req    <= 1'b0;
            miss_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inval) begin
                        valid <= '0;
                    end else if (!hit) begin
                        miss_addr  <= pc_f[31:2];
                        mem_req    <= 1'b1;
                        inval_pend <= 1'b0;
                        state      <= REFILL;
                        if (miss_cnt != 16'hFFFF)
                            miss_cnt <= miss_cnt + 16'd1;
                    end
                end
                REFILL: begin
                    if (inval)
                        inval_pend <= 1'b1;
                    if (mem_ack) begin
                        // An invalidate seen at any point during the refill
                        // wins over the freshly written line.
                        if (inval_pend || inval)
                            valid <= '0;
                        else
                            valid[fill_idx] <= 1'b1;
                        inval_pend <= 1'b0;
                        mem_req    <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_cache.md
INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 SHALL have parameter LINES, default 16, meaning number of one-word direct-mapped lines (power of 2, 2..256).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port srst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port pc_f  input  32  fetch address from the fetch stage; bits[1:0] ignored.
REQ-005 SHALL have port inval  input  1  invalidate-all request, level-sampled per cycle.
REQ-006 SHALL have port instr_f  output  32  instruction word returned to the fetch stage.
REQ-007 SHALL have port stall_o  output  1  high when instr_f is not valid for pc_f; drives the fetch and decode stall inputs.
REQ-008 SHALL have port mem_req  output  1  refill request to backing memory.
REQ-009 SHALL have port mem_addr  output  32  word-aligned refill address, bits[1:0]=0.
REQ-010 SHALL have port mem_ack  input  1  backing memory completion strobe.
REQ-011 SHALL have port mem_rdata  input  32  refill data, valid only in a cycle with mem_ack=1.
REQ-012 SHALL have port miss_cnt  output  16  saturating count of refills started.

Function
REQ-013 SHALL use IB=log2(LINES): index=pc_f[IB+1:2], tag=pc_f[31:IB+2]; per line, store valid, tag, data.
REQ-014 SHALL compute hit combinationally: state==IDLE, valid[index]=1, stored tag==tag.
REQ-015 SHALL drive instr_f=data[index] on hit, else 32'h00000013 (NOP); stall_o=!hit.
REQ-016 SHALL implement FSM states IDLE and REFILL.
REQ-017 SHALL, in IDLE on a miss with inval=0, latch pc_f[31:2] as miss address, increment miss_cnt, and go to REFILL next cycle.
REQ-018 SHALL, in REFILL, hold mem_req=1 and mem_addr={miss address,2'b00} stable every cycle until mem_ack=1 is sampled.
REQ-019 SHALL, on a REFILL cycle with mem_ack=1, write mem_rdata, tag, and valid=1 into the latched index at that edge, deassert mem_req, and return to IDLE.
REQ-020 SHALL give miss latency: miss at cycle 0, mem_req high from cycle 1, ack at cycle k>=1, hit at cycle k+1 if pc_f unchanged.
REQ-021 SHALL keep mem_req=0 in IDLE and ignore mem_ack while in IDLE.
REQ-022 SHALL complete an outstanding refill with the latched address if pc_f changes during REFILL (e.g. branch redirect), then re-evaluate the new pc_f in IDLE.
REQ-023 SHALL, on inval=1 in IDLE, clear all valid bits at that edge and start no refill that cycle.
REQ-024 SHALL, on inval=1 in any REFILL cycle, record a pending invalidate; at refill completion, write the line and clear all valid bits, so no line is valid afterwards.
REQ-025 SHALL saturate miss_cnt at 16'hFFFF without wrap.
REQ-026 SHALL overwrite the resident line on a conflict miss (same index, different tag) with no replacement choice.

Reset
REQ-027 SHALL, on srst=0 at a rising edge, set state=IDLE, clear all valid bits, clear the pending invalidate, and set miss_cnt=0; tag and data arrays need not reset.
REQ-028 SHALL give mem_req=0 from the first edge with srst=0, even mid-REFILL; a mem_ack arriving afterwards SHALL be ignored.
REQ-029 SHALL, while in reset, output stall_o=1 and instr_f=32'h00000013, since all lines are invalid.

Verification
REQ-030 SHALL test cold miss: reset, pc_f=0x100, mem_ack after 3 REFILL cycles with rdata=0x00500093 -> mem_addr=0x100 held 3 cycles, instr_f=0x00500093 and stall_o=0 on the next cycle, miss_cnt=1.
REQ-031 SHALL test hit: after REQ-030, pc_f=0x104 then back to 0x100 -> 0x104 misses (miss_cnt=2); 0x100 hits with stall_o=0 and no mem_req.
REQ-032 SHALL test conflict: LINES=16, fill 0x100, then pc_f=0x140 (same index 0) -> refill at 0x140; returning to 0x100 misses again.
REQ-033 SHALL test inval during REFILL: assert inval one cycle mid-refill -> refill completes, then a subsequent access to the same pc misses.
REQ-034 SHALL test reset mid-refill: srst=0 while mem_req=1, then mem_ack=1 -> mem_req=0, no line written, miss_cnt=0.
REQ-035 SHALL test redirect: pc_f changes 0x200->0x300 during REFILL -> fill at 0x200 completes, then a new refill at 0x300 starts in the cycle after return to IDLE.
